// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one simple memory port among NUM_REQ requesters.
// One access at a time, at least two idle cycles between accesses, watchdog-bounded.
module mem_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0]      req_rnw_i,
  input  logic [4*NUM_REQ-1:0]    req_addr_i,
  input  logic [32*NUM_REQ-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    req_err_o,
  output logic [31:0]             req_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_rnw_o,
  output logic [3:0]              mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  input  logic                    mem_ready_i,
  input  logic [31:0]             mem_rdata_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [WD_W-1:0]    wd_q;
  logic               mem_req_q;
  logic               mem_rnw_q;
  logic [3:0]         mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic               req_err_q;
  logic [31:0]        req_rdata_q;

  logic               grant_vld_d;
  logic [IDX_W-1:0]   grant_d;
  logic [IDX_W-1:0]   rr_ptr_d;
  logic [IDX_W:0]     scan_sum;
  logic [IDX_W-1:0]   scan_idx;

  // First set request at or above the rr pointer, wrapping modulo NUM_REQ.
  always_comb begin
    // NOTE: every comb output gets a default before any conditional write, so no latch is inferred.
    grant_vld_d = 1'b0;
    grant_d     = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
      if (scan_sum >= NUM_REQ_W) begin
        scan_sum = scan_sum - NUM_REQ_W;
      end
      scan_idx = scan_sum[IDX_W-1:0];
      if (!grant_vld_d && req_i[scan_idx]) begin
        grant_vld_d = 1'b1;
        grant_d     = scan_idx;
      end
    end
    rr_ptr_d = (grant_d == IDX_LAST) ? '0 : grant_d + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      wd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_rnw_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      req_ready_q <= '0;
      req_err_q   <= 1'b0;
      req_rdata_q <= '0;
    end else begin
      // Completion outputs are single-cycle; only the ACCESS exit sets them.
      req_ready_q <= '0;
      req_err_q   <= 1'b0;
      req_rdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_vld_d) begin
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_rnw_q   <= req_rnw_i[grant_d];
            mem_addr_q  <= req_addr_i[grant_d*4 +: 4];
            mem_wdata_q <= req_wdata_i[grant_d*32 +: 32];
            mem_req_q   <= 1'b1;
            wd_q        <= '0;
            state_q     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_ready_i) begin
            req_ready_q[grant_q] <= 1'b1;
            req_rdata_q          <= mem_rnw_q ? mem_rdata_i : 32'h0;
            mem_req_q            <= 1'b0;
            state_q              <= S_RESP;
          end else if (wd_q == WD_LAST) begin
            req_ready_q[grant_q] <= 1'b1;
            req_err_q            <= 1'b1;
            mem_req_q            <= 1'b0;
            state_q              <= S_RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_RESP: begin
          wd_q    <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign req_err_o   = req_err_q;
  assign req_rdata_o = req_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_rnw_o   = mem_rnw_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: vector table, directed multi-cycle sequences and
// randomized traffic against a transaction-level reference model.
module tb_mem_rr_arbiter;

  localparam int N  = 3;
  localparam int TO = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_i, req_rnw_i;
  logic [4*N-1:0]   req_addr_i;
  logic [32*N-1:0]  req_wdata_i;
  logic [N-1:0]     req_ready_o;
  logic             req_err_o;
  logic [31:0]      req_rdata_o;
  logic             mem_req_o, mem_rnw_o;
  logic [3:0]       mem_addr_o;
  logic [31:0]      mem_wdata_o;
  logic             mem_ready_i;
  logic [31:0]      mem_rdata_i;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .req_rnw_i   (req_rnw_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_ready_o (req_ready_o),
    .req_err_o   (req_err_o),
    .req_rdata_o (req_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_rnw_o   (mem_rnw_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 5) ? 32'hDEADBEEF : (32'hC0DE_0000 | 32'(i));
  endfunction

  // Memory model: latency counted from the rising edge of mem_req_o; mem_lat<0 means random 0..15.
  logic [31:0] mem [16];
  int acc_cyc = 0;
  int cur_lat = 0;
  int mem_lat = 0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (mem_req_o && mem_ready_i && !mem_rnw_o) begin
      mem[mem_addr_o] <= mem_wdata_o;
    end
    if (!mem_req_o) begin
      acc_cyc <= 0;
      cur_lat <= (mem_lat < 0) ? int'($urandom_range(0, 15)) : mem_lat;
    end else begin
      acc_cyc <= acc_cyc + 1;
    end
  end

  assign mem_ready_i = mem_req_o && (acc_cyc == cur_lat);
  assign mem_rdata_i = (mem_req_o && mem_rnw_o) ? mem[mem_addr_o] : 32'hA5A5_A5A5;

  // Requester-side state and reference memory
  logic [N-1:0] a_req, a_rnw;
  logic [3:0]   a_addr  [N];
  logic [31:0]  a_wdata [N];
  logic [31:0]  exp_mem [16];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    req_i     = a_req;
    req_rnw_i = a_rnw;
    for (int k = 0; k < N; k++) begin
      req_addr_i[4*k +: 4]   = a_addr[k];
      req_wdata_i[32*k +: 32] = a_wdata[k];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    a_req = '0;
    drive();
    @(negedge clk);
    check("reset mem_req_o", mem_req_o, 0);
    check("reset req_ready_o", req_ready_o, 0);
    check("reset rdata/err", {req_err_o, req_rdata_o}, 0);
    check("reset mem attrs", {mem_rnw_o, mem_addr_o, mem_wdata_o}, 0);
    for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
    reset = 1'b0;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (!mem_req_o && n < 8) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    while (req_ready_o == '0 && n < TO + 6) begin
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         rnw;
    logic [3:0]   addr;
    logic [31:0]  wdata;
    int           lat;
    int           exp_grant;
    logic [31:0]  exp_rdata;
  } vec_t;

  vec_t vecs [8];

  // Applies one vector from IDLE; the winner gets the vector's attributes, the others their complements.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    logic [N-1:0] oh;
    for (int k = 0; k < N; k++) begin
      a_req[k]   = v.req[k];
      a_rnw[k]   = v.rnw;
      a_addr[k]  = (k == v.exp_grant) ? v.addr : ~v.addr;
      a_wdata[k] = (k == v.exp_grant) ? v.wdata : ~v.wdata;
    end
    mem_lat = v.lat;
    drive();
    @(negedge clk);
    check($sformatf("vec%0d mem_req after 1 cycle", idx), mem_req_o, 1);
    check($sformatf("vec%0d mem addr/rnw", idx), {mem_rnw_o, mem_addr_o}, {v.rnw, v.addr});
    if (!v.rnw) check($sformatf("vec%0d mem wdata", idx), mem_wdata_o, v.wdata);
    a_req = '0;
    drive();
    wait_pulse(n);
    oh = '0;
    oh[v.exp_grant] = 1'b1;
    check($sformatf("vec%0d ready latency", idx), n, v.lat + 1);
    check($sformatf("vec%0d ready grant", idx), req_ready_o, oh);
    check($sformatf("vec%0d rdata/err", idx), {req_err_o, req_rdata_o}, {1'b0, v.exp_rdata});
    @(negedge clk);
    check($sformatf("vec%0d pulse width", idx), {req_ready_o, req_err_o, req_rdata_o}, 0);
    check($sformatf("vec%0d gap cycle 1", idx), mem_req_o, 0);
    @(negedge clk);
    check($sformatf("vec%0d gap cycle 2", idx), mem_req_o, 0);
  endtask

  initial begin
    int n, w, c, m_w, m_ptr, low_cnt, hi_cnt, cyc;
    logic m_busy, prev_req;
    logic [N-1:0] oh;
    logic [31:0] exp_rd;

    reset = 1'b1;
    a_req = '0;
    a_rnw = '0;
    for (int k = 0; k < N; k++) begin
      a_addr[k]  = '0;
      a_wdata[k] = '0;
    end
    drive();

    // req, rnw, addr, wdata, lat, grant, rdata (rr pointer starts at 0 after reset)
    vecs[0] = '{3'b001, 1'b1, 4'h5, 32'h0,        0,  0, 32'hDEADBEEF};
    vecs[1] = '{3'b100, 1'b0, 4'hA, 32'h12345678, 3,  2, 32'h0};
    vecs[2] = '{3'b100, 1'b1, 4'hA, 32'h0,        7,  2, 32'h12345678};
    vecs[3] = '{3'b101, 1'b1, 4'h5, 32'h0,        2,  0, 32'hDEADBEEF};
    vecs[4] = '{3'b101, 1'b1, 4'hA, 32'h0,        15, 2, 32'h12345678};
    vecs[5] = '{3'b011, 1'b0, 4'h3, 32'hCAFEF00D, 1,  0, 32'h0};
    vecs[6] = '{3'b011, 1'b1, 4'h3, 32'h0,        4,  1, 32'hCAFEF00D};
    vecs[7] = '{3'b110, 1'b1, 4'h0, 32'h0,        0,  2, 32'hC0DE0000};

    do_reset();
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // All requesters continuously requesting: grants rotate 0,1,2,0,1,2
    do_reset();
    mem_lat = 2;
    a_req = '1;
    a_rnw = '1;
    for (int k = 0; k < N; k++) a_addr[k] = 4'(4 + k);
    drive();
    for (int i = 0; i < 6; i++) begin
      wait_rise(n);
      check($sformatf("rot%0d mem_req rise", i), mem_req_o, 1);
      check($sformatf("rot%0d mem_addr", i), mem_addr_o, a_addr[i % N]);
      wait_pulse(n);
      oh = '0;
      oh[i % N] = 1'b1;
      check($sformatf("rot%0d grant", i), req_ready_o, oh);
      check($sformatf("rot%0d rdata", i), req_rdata_o, init_word(4 + (i % N)));
      @(negedge clk);
      check($sformatf("rot%0d pulse width", i), req_ready_o, 0);
    end
    a_req = '0;
    drive();
    repeat (4) @(negedge clk);

    // Watchdog: ready stuck low
    mem_lat = 1000;
    a_req = 3'b010;
    a_rnw = 3'b010;
    a_addr[1] = 4'h7;
    drive();
    wait_rise(n);
    check("timeout mem_req rise", mem_req_o, 1);
    n = 0;
    while (mem_req_o && n < TO + 10) begin
      n++;
      @(negedge clk);
    end
    check("timeout mem_req high cycles", n, TO);
    check("timeout pulse", req_ready_o, 3'b010);
    check("timeout err/rdata", {req_err_o, req_rdata_o}, {1'b1, 32'h0});
    a_req = '0;
    drive();
    @(negedge clk);
    check("timeout back to idle", {mem_req_o, req_ready_o, req_err_o}, 0);
    @(negedge clk);
    check("timeout stays idle", mem_req_o, 0);

    // Reset during cycle 3 of an access
    a_req = 3'b100;
    a_rnw = 3'b100;
    a_addr[2] = 4'h2;
    drive();
    wait_rise(n);
    check("abort mem_req rise", mem_req_o, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    a_req = '0;
    drive();
    @(negedge clk);
    check("abort mem_req drops", mem_req_o, 0);
    check("abort no pulse", req_ready_o, 0);
    @(negedge clk);
    check("abort no pulse later", req_ready_o, 0);
    for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
    reset = 1'b0;
    mem_lat = 1;
    a_req = '1;
    a_rnw = '1;
    for (int k = 0; k < N; k++) a_addr[k] = 4'(8 + k);
    drive();
    @(negedge clk);
    check("post-reset mem_req", mem_req_o, 1);
    check("post-reset addr of req0", mem_addr_o, 4'h8);
    wait_pulse(n);
    check("post-reset grant", req_ready_o, 3'b001);
    a_req = '0;
    drive();

    // Randomized traffic against the transaction-level model
    do_reset();
    mem_lat = -1;
    m_ptr = 0;
    m_w = 0;
    m_busy = 1'b0;
    prev_req = 1'b0;
    low_cnt = 100;
    hi_cnt = 0;
    cyc = 0;
    while (cyc < 900 && (cyc < 600 || a_req != '0 || m_busy)) begin
      @(negedge clk);
      if (mem_req_o && !prev_req) begin
        check("rnd gap >= 2", low_cnt >= 2, 1);
        check("rnd single access", m_busy, 0);
        w = -1;
        for (int i = 0; i < N; i++) begin
          c = (m_ptr + i) % N;
          if (w < 0 && a_req[c]) w = c;
        end
        check("rnd grant has requester", w >= 0, 1);
        if (w < 0) w = 0;
        check("rnd mem addr/rnw", {mem_rnw_o, mem_addr_o}, {a_rnw[w], a_addr[w]});
        if (!a_rnw[w]) check("rnd mem wdata", mem_wdata_o, a_wdata[w]);
        m_w = w;
        m_busy = 1'b1;
        m_ptr = (w + 1) % N;
        hi_cnt = 0;
      end
      if (mem_req_o) begin
        hi_cnt++;
        low_cnt = 0;
      end else begin
        low_cnt++;
      end
      if (req_ready_o != '0) begin
        oh = '0;
        oh[m_w] = 1'b1;
        check("rnd completion owner", {m_busy, req_ready_o}, {1'b1, oh});
        check("rnd access length", hi_cnt <= 16, 1);
        exp_rd = a_rnw[m_w] ? exp_mem[a_addr[m_w]] : 32'h0;
        check("rnd rdata/err", {req_err_o, req_rdata_o}, {1'b0, exp_rd});
        if (!a_rnw[m_w]) exp_mem[a_addr[m_w]] = a_wdata[m_w];
        a_req[m_w] = 1'b0;
        m_busy = 1'b0;
      end else begin
        check("rnd idle rdata/err", {req_err_o, req_rdata_o}, 0);
      end
      prev_req = mem_req_o;
      for (int k = 0; k < N; k++) begin
        if (!a_req[k] && cyc < 600 && $urandom_range(0, 2) == 0) begin
          a_req[k]   = 1'b1;
          a_rnw[k]   = 1'($urandom_range(0, 1));
          a_addr[k]  = 4'($urandom_range(0, 15));
          a_wdata[k] = $urandom;
        end
      end
      drive();
      cyc++;
    end
    check("rnd drained", {a_req, m_busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Round-robin arbiter sharing the single-port simple memory interface (16 x 32-bit, 4-bit address, random-latency ready) between NUM_REQ requesters.
- Grants one requester at a time and drives the memory request until memory ready.
- Forces at least two idle cycles between accesses so every access presents a fresh rising edge on the memory request, which reloads the memory's random-delay counter.
- Returns read data and done/error per requester; a watchdog bounds a stuck access.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
TIMEOUT, 20, max cycles in ACCESS before forced error completion (>=17, since memory latency is at most 16)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_i  in  NUM_REQ  per-requester request; held until that requester's req_ready_o pulse
req_rnw_i  in  NUM_REQ  per-requester 1=read, 0=write
req_addr_i  in  4*NUM_REQ  per-requester address, requester k at [4k+3:4k]
req_wdata_i  in  32*NUM_REQ  per-requester write data, requester k at [32k+31:32k]
req_ready_o  out  NUM_REQ  one-cycle completion pulse to the granted requester
req_err_o  out  1  valid with req_ready_o; 1 = access timed out
req_rdata_o  out  32  read data, valid with req_ready_o; 0 for writes and errors
mem_req_o  out  1  memory request
mem_rnw_o  out  1  memory read/not-write
mem_addr_o  out  4  memory address
mem_wdata_o  out  32  memory write data
mem_ready_i  in  1  memory ready (combinational from memory)
mem_rdata_i  in  32  memory read data (combinational, valid while mem_req_o and mem_rnw_o)

Behaviour:
- Reset: state IDLE, all outputs 0, rr pointer 0 (requester 0 highest priority), watchdog 0. Reset has priority over all other events.
- Reset mid-access: mem_req_o is 0 from the cycle after reset is sampled. No req_ready_o pulse is issued, and the aborted transaction is lost.
- IDLE state:
  - mem_req_o=0.
  - If any req_i is set, select the first set bit searching from the rr pointer upward with wrap.
  - Latch grant index, rnw, addr and wdata into the mem_* output registers.
  - Set rr pointer = grant+1 mod NUM_REQ, then go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS state:
  - mem_req_o=1; mem_* attributes stay stable; watchdog increments each cycle.
  - If mem_ready_i=1: capture mem_rdata_i if read (0 if write), set err=0, go to RESP. A write commits in the memory in this same cycle.
  - Else if watchdog reaches TIMEOUT-1: capture rdata=0, set err=1, go to RESP.
  - mem_ready_i wins over timeout when both occur in the same cycle.
- RESP state:
  - mem_req_o=0.
  - req_ready_o[grant]=1 for exactly this cycle, with req_rdata_o and req_err_o driven from the captured registers.
  - Clear watchdog, then go to IDLE.
  - req_rdata_o and req_err_o return to 0 in all other cycles.
- Minimum latency: request seen in IDLE at cycle 0 -> mem_req_o=1 at cycle 1 -> if mem_ready_i at cycle k, req_ready_o at cycle k+1.
- Gap: mem_req_o is low for at least 2 cycles (RESP, IDLE) between accesses.
- Handshake: requester k must hold req_i[k] and its attributes stable until it sees req_ready_o[k].
  - req_i[k] still set in the cycle after the pulse is a new request.
  - The arbiter ignores req_i in ACCESS and RESP.
  - Dropping req_i[k] after grant does not abort the access.
- Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,2,0,... No requester waits more than NUM_REQ-1 accesses.
- mem_ready_i seen in IDLE or RESP is ignored.
- The arbiter never issues more than one access at a time.

Test Plan:
- Reset, then single read: req_i=3'b001, addr=4'h5, memory preloaded with 32'hDEADBEEF -> mem_req_o rises 1 cycle later; req_ready_o=3'b001 one cycle after mem_ready_i; req_rdata_o=32'hDEADBEEF, req_err_o=0.
- Write then read: requester 2 writes 32'h12345678 to addr 4'hA, then reads addr 4'hA -> read returns 32'h12345678 with req_rdata_o=0 on the write completion; mem_req_o low for >=2 cycles between the accesses.
- All three requesting continuously, 6 accesses -> grant order 0,1,2,0,1,2; each req_ready_o pulse is exactly 1 cycle wide, and mem_addr_o matches the granted requester's address.
- Pointer wrap: after requester 2 is served, req_i=3'b101 -> requester 0 granted before requester 2.
- Memory model with ready stuck 0, TIMEOUT=20 -> mem_req_o high exactly 20 cycles; then req_ready_o pulse with req_err_o=1, req_rdata_o=0, followed by return to IDLE.
- Assert reset during ACCESS (cycle 3 of access) -> mem_req_o=0 next cycle, no req_ready_o pulse; the next request after reset is granted to requester 0 first.
